aes_block_loader: RTL and testbench

- Byte-serial front/back end for the AES Cipher/InvCipher datapath; it is the stimulus side that the current self-checking top lacks.
- Accepts a 16-byte key then a 16-byte text block over a valid/ready byte stream and presents them as 128-bit words to the core.
- Waits a fixed core latency, captures the 128-bit result, then streams it back out byte-serially under valid/ready back-pressure.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_byte_serializer.sv | 60 ++++++
 rtl/aes_block_loader.sv | 143 ++++++++++++++
 tb/tb_aes_block_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES byte-serial loader slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   aes_state_t  - loader FSM states
//   aes_block_t  - 128-bit block in [0:127] order, byte 0 in bits [0:7]
//   aesSetByte   - returns a block with one byte replaced
package aes_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_BYTE_W      = 8;
  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    LOAD_KEY  = 2'd0,
    LOAD_TEXT = 2'd1,
    WAIT      = 2'd2,
    SEND      = 2'd3
  } aes_state_t;

  typedef logic [0:AES_BLOCK_W-1] aes_block_t;

  // Byte idx occupies bits [8*idx : 8*idx+7]; with the ascending range that is
  // the idx-th byte counting from the most significant end.
  function automatic aes_block_t aesSetByte(input aes_block_t blk,
                                            input logic [3:0] idx,
                                            input logic [AES_BYTE_W-1:0] val);
    aes_block_t res;
    res = blk;
    res[AES_BYTE_W*idx +: AES_BYTE_W] = val;
    return res;
  endfunction

endpackage

// File: rtl/aes_byte_serializer.sv
// Purpose: streams a captured 128-bit result out one byte at a time, [0:7] first.
// Latency: first byte valid the cycle after load; one byte per accepted cycle.
// Backpressure: out_ready low stalls indefinitely with out_data held stable.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   load          - capture loadData into the shift register, raise out_valid
//   loadData      - block to serialize
//   out_valid     - output byte valid
//   out_ready     - downstream accepts byte
//   out_data      - current byte (shift register bits [0:7])
//   done          - high in the cycle the 16th byte is transferred
module aes_byte_serializer
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  aes_block_t            loadData,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_BYTE_W-1:0] out_data,
  output logic                  done
);

  aes_block_t shiftReg;
  logic [3:0] sentCnt;
  logic       validReg;
  logic       xfer;
  logic       lastByte;

  assign xfer     = validReg && out_ready;
  assign lastByte = (sentCnt == 4'(AES_BLOCK_BYTES - 1));
  assign done     = xfer && lastByte;

  assign out_valid = validReg;
  assign out_data  = shiftReg[0:AES_BYTE_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg <= '0;
      sentCnt  <= '0;
      validReg <= 1'b0;
    end else if (load) begin
      shiftReg <= loadData;
      sentCnt  <= '0;
      validReg <= 1'b1;
    end else if (xfer) begin
      // Zero fill means out_data reads 0 once the block is fully drained.
      shiftReg <= {shiftReg[AES_BYTE_W:AES_BLOCK_W-1], {AES_BYTE_W{1'b0}}};
      if (lastByte) begin
        sentCnt  <= '0;
        validReg <= 1'b0;
      end else begin
        sentCnt  <= sentCnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Purpose: byte-serial key/text loader and result unloader around an AES core.
// Latency: start one cycle after the last text byte; result captured CORE_LATENCY cycles later.
// Backpressure: in_ready only in load states; out_ready low stalls the byte output indefinitely.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset (wins over everything)
//   in_valid/in_ready   - input byte handshake, in_data the byte
//   key, text           - assembled 128-bit words, byte 0 in bits [0:7]
//   start               - one-cycle pulse when key and text are complete
//   result              - core output, sampled CORE_LATENCY cycles after start
//   out_valid/out_ready - output byte handshake, out_data the byte
//   busy                - low only in a load state with no byte collected yet
//
// Build option: AES_LOADER_KEY_HOLD_EN - when defined, the key is kept after a
// block is sent and the next block needs only its 16 text bytes.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int CORE_LATENCY = 11,
  parameter int BYTES        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_BYTE_W-1:0] in_data,
  output aes_block_t            key,
  output aes_block_t            text,
  output logic                  start,
  input  aes_block_t            result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_BYTE_W-1:0] out_data,
  output logic                  busy
);

  aes_state_t state;
  aes_state_t nextState;
  logic [3:0] byteCnt;
  logic [7:0] waitCnt;
  aes_block_t keyReg;
  aes_block_t textReg;
  logic       startReg;

  logic accept;
  logic lastByte;
  logic inLoad;
  logic serLoad;
  logic serDone;

  assign lastByte = (byteCnt == 4'(BYTES - 1));
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state and combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    nextState = state;
    inLoad    = 1'b0;
    serLoad   = 1'b0;

    case (state)
      LOAD_KEY: begin
        inLoad = 1'b1;
        if (in_valid && lastByte) nextState = LOAD_TEXT;
      end
      LOAD_TEXT: begin
        inLoad = 1'b1;
        if (in_valid && lastByte) nextState = WAIT;
      end
      WAIT: begin
        // The counter reaches zero exactly CORE_LATENCY edges after the
        // start pulse begins, so the result is sampled on the next edge.
        if (waitCnt == 8'd0) begin
          serLoad   = 1'b1;
          nextState = SEND;
        end
      end
      SEND: begin
        if (serDone) begin
`ifdef AES_LOADER_KEY_HOLD_EN
          nextState = LOAD_TEXT;
`else
          nextState = LOAD_KEY;
`endif
        end
      end
      default: nextState = LOAD_KEY;
    endcase
  end

  assign in_ready = inLoad;
  assign busy     = !(inLoad && (byteCnt == 4'd0));

  // ---------------------------------------------------------------------------
  // State, byte assembly and wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD_KEY;
      byteCnt  <= '0;
      waitCnt  <= '0;
      keyReg   <= '0;
      textReg  <= '0;
      startReg <= 1'b0;
    end else begin
      state    <= nextState;
      startReg <= (state == LOAD_TEXT) && accept && lastByte;

      if (accept) begin
        // 4-bit counter wraps to 0 after the 16th byte.
        byteCnt <= byteCnt + 4'd1;
        if (state == LOAD_KEY) keyReg  <= aesSetByte(keyReg,  byteCnt, in_data);
        else                   textReg <= aesSetByte(textReg, byteCnt, in_data);
      end

      if ((state == LOAD_TEXT) && accept && lastByte) begin
        waitCnt <= 8'(CORE_LATENCY);
      end else if ((state == WAIT) && (waitCnt != 8'd0)) begin
        waitCnt <= waitCnt - 8'd1;
      end
    end
  end

  assign key   = keyReg;
  assign text  = textReg;
  assign start = startReg;

  // ---------------------------------------------------------------------------
  // Output side
  // ---------------------------------------------------------------------------
  aes_byte_serializer uSer (
    .clk       (clk),
    .reset     (reset),
    .load      (serLoad),
    .loadData  (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (serDone)
  );

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: directed phases with random data,
// expected words and output bytes derived from the byte streams themselves.
module tb_aes_block_loader;
  import aes_pkg::*;

  localparam int LAT = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  aes_block_t key;
  aes_block_t text;
  logic       start;
  aes_block_t result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] stim[32];

  always #5 clk = ~clk;

  aes_block_loader #(.CORE_LATENCY(LAT), .BYTES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key       (key),
    .text      (text),
    .start     (start),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word as the bytes would read left to right: first byte is most significant.
  function automatic logic [127:0] word16(input int first);
    logic [127:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = (acc << 8) | 128'(stim[first + i]);
    return acc;
  endfunction

  task automatic checkReset();
    chk("rst_key", key, 0);
    chk("rst_text", text, 0);
    chk("rst_start", start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
  endtask

  // Called at a time just after a posedge; leaves reset deasserted.
  task automatic applyReset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkReset();
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pushByte(input logic [7:0] b, input bit gaps, output bit ok);
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic feed(input int first, input int n, input bit gaps, input string tag);
    bit ok;
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      pushByte(stim[first + i], gaps, ok);
      if (!ok) bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Starts right after the edge that accepted the last text byte.
  task automatic waitPhase(input bit holdValid, input logic [127:0] eKey,
                           input logic [127:0] eText, input string tag);
    int firstValid;
    int extraStart;
    int consumed;
    int drift;
    logic startAt1;
    firstValid = -1; extraStart = 0; consumed = 0; drift = 0; startAt1 = 1'b0;
    if (holdValid) begin
      in_valid = 1'b1;
      in_data  = 8'hA5;
    end
    for (int k = 1; k <= LAT + 10 && firstValid < 0; k++) begin
      @(negedge clk);
      if (k == 1) startAt1 = start;
      else if (start) extraStart++;
      if (out_valid) firstValid = k;
      else if (in_ready) consumed++;
      if (key !== eKey || text !== eText) drift++;
    end
    in_valid = 1'b0;
    chk({tag, "_key"}, key, eKey);
    chk({tag, "_text"}, text, eText);
    chk({tag, "_start_pulse"}, startAt1, 1);
    chk({tag, "_start_once"}, extraStart, 0);
    chk({tag, "_result_latency"}, firstValid, LAT + 2);
    chk({tag, "_wait_ready_low"}, consumed, 0);
    chk({tag, "_wait_kt_stable"}, drift, 0);
  endtask

  // Starts at a negedge with out_valid already high.
  task automatic drain(input logic [127:0] res, input int sA, input int sB, input int sC,
                       input int abortAt, input logic [127:0] eKey, input logic [127:0] eText,
                       input string tag);
    logic [7:0] expB[16];
    int idx;
    int stall;
    bit acc;
    for (int i = 0; i < 16; i++) expB[i] = res[127 - 8*i -: 8];
    idx = 0;
    stall = (sA == 0 || sB == 0 || sC == 0) ? 5 : 0;
    out_ready = (stall == 0);
    for (int t = 0; t < 200 && idx < 16; t++) begin
      if (idx == abortAt) return;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_byte"}, out_data, expB[idx]);
      acc = out_valid && out_ready;
      if (out_valid && !out_ready) stall--;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        stall = (idx == sA || idx == sB || idx == sC) ? 5 : 0;
      end
      out_ready = (stall == 0);
      if (idx < 16) @(negedge clk);
    end
    chk({tag, "_count"}, idx, 16);
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_key_after"}, key, eKey);
    chk({tag, "_text_after"}, text, eText);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] kD;
    logic [127:0] tD;
    logic [127:0] r;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; result = '0;
    @(posedge clk); #1;
    applyReset();

    // Block A: incrementing key, 00 11 .. ff text, known result, no gaps.
    for (int i = 0; i < 16; i++) begin
      stim[i]      = 8'(i);
      stim[16 + i] = 8'(i * 17);
    end
    result = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    feed(0, 1, 1'b0, "a_first");
    @(negedge clk);
    chk("a_busy_after_one", busy, 1);
    @(posedge clk); #1;
    feed(1, 31, 1'b0, "a_feed");
    waitPhase(1'b0, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, "a");
    drain(128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, -1, -1, -1,
          128'h000102030405060708090a0b0c0d0e0f,
          128'h00112233445566778899aabbccddeeff, "a_out");

    // Block B: random data, gaps, in_valid held through WAIT, stalls at 0/7/15.
    for (int i = 0; i < 32; i++) stim[i] = 8'($urandom);
    r = {$urandom, $urandom, $urandom, $urandom};
    result = r;
    feed(0, 32, 1'b1, "b_feed");
    waitPhase(1'b1, word16(0), word16(16), "b");
    drain(r, 0, 7, 15, -1, word16(0), word16(16), "b_out");

    // Reset during LOAD_TEXT after 9 text bytes.
    for (int i = 0; i < 32; i++) stim[i] = 8'($urandom);
    feed(0, 25, 1'b0, "c_feed");
    applyReset();

    // Reset during SEND with four bytes already out.
    r = {$urandom, $urandom, $urandom, $urandom};
    result = r;
    feed(0, 32, 1'b1, "d_feed");
    waitPhase(1'b0, word16(0), word16(16), "d");
    drain(r, -1, -1, -1, 4, word16(0), word16(16), "d_out");
    out_ready = 1'b0;
    applyReset();

    // Full block after the reset, random gaps.
    for (int i = 0; i < 32; i++) stim[i] = 8'($urandom);
    r = {$urandom, $urandom, $urandom, $urandom};
    result = r;
    feed(0, 32, 1'b1, "e_feed");
    kD = word16(0);
    tD = word16(16);
    waitPhase(1'b0, kD, tD, "e");
    drain(r, 3, -1, -1, -1, kD, tD, "e_out");

    // Second block of only 16 bytes.
    for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
    r = {$urandom, $urandom, $urandom, $urandom};
    result = r;
    feed(0, 16, 1'b0, "f_feed");
`ifdef AES_LOADER_KEY_HOLD_EN
    waitPhase(1'b0, kD, word16(0), "f");
    drain(r, -1, -1, -1, -1, kD, word16(0), "f_out");
`else
    begin
      int starts;
      starts = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (start) starts++;
      end
      chk("f_no_start", starts, 0);
      chk("f_key_loaded", key, word16(0));
      chk("f_text_kept", text, tD);
      chk("f_in_ready", in_ready, 1);
      chk("f_busy", busy, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
